// File: rtl/hdub_core_logic_bin_gate_pipe_pkg.sv
// Shared types for the bitwise gate datapath: op codes, accumulate FSM states
// and the gate evaluation function used by the pipe front end.
package hdub_core_logic_gate;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } gate_op_e;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic                 err;
    logic [MAX_WIDTH-1:0] y;
  } gate_res_t;

  // Operands are zero-extended to MAX_WIDTH by the caller; only the low WIDTH bits matter.
  function automatic gate_res_t gate_eval(input gate_op_e op,
                                          input logic [MAX_WIDTH-1:0] a,
                                          input logic [MAX_WIDTH-1:0] b);
    gate_res_t r;
    r.err = 1'b0;
    r.y   = '0;
    case (op)
      OP_AND:  r.y = a & b;
      OP_OR:   r.y = a | b;
      OP_XOR:  r.y = a ^ b;
      OP_NAND: r.y = ~(a & b);
      OP_NOR:  r.y = ~(a | b);
      OP_XNOR: r.y = ~(a ^ b);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hdub_core_logic_bin_gate_pipe_stage.sv
// One elastic pipeline register: valid bit plus payload, loaded when en is high.
module hdub_core_logic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/hdub_core_logic_bin_gate_pipe.sv
// Runtime-selectable bitwise gate with optional frame accumulator, followed by
// STAGES lock-step valid/ready registers that all advance together.
module hdub_core_logic_bin_gate_pipe
  import hdub_core_logic_gate::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGES     = 2,
  parameter int ACC_ENABLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_last,
  output logic             out_err
);

  localparam int PW = WIDTH + 2;

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "hdub_core_logic_bin_gate_pipe: STAGES must be >= 1");
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "hdub_core_logic_bin_gate_pipe: WIDTH out of range");
  end

  logic                 advance, accept, acc_beat;
  acc_state_e           state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [MAX_WIDTH-1:0] op_a, op_b;
  gate_res_t            res;
  logic [WIDTH-1:0]     y_d;
  logic                 err_d, last_d;
  logic                 unused_res;

  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance && !rst;
  assign unused_res = ^res.y;

  always_comb begin
    accept   = in_valid && in_ready;
    acc_beat = (ACC_ENABLE != 0) && in_acc;
    op_a     = '0;
    op_b     = '0;
    // Accumulating beats fold in_a into the running value; in_b is ignored.
    if (acc_beat) begin
      op_a[WIDTH-1:0] = acc_q;
      op_b[WIDTH-1:0] = in_a;
    end else begin
      op_a[WIDTH-1:0] = in_a;
      op_b[WIDTH-1:0] = in_b;
    end
    res    = gate_eval(gate_op_e'(in_op), op_a, op_b);
    err_d  = res.err;
    last_d = acc_beat && in_last;
    y_d    = res.y[WIDTH-1:0];
    if (acc_beat && state_q == ACC_IDLE) begin
      y_d = res.err ? '0 : in_a;
    end

    state_d = state_q;
    acc_d   = acc_q;
    if (accept && acc_beat) begin
      if (!res.err) acc_d = y_d;
      state_d = in_last ? ACC_IDLE : ACC_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  logic [STAGES:0] stg_valid;
  logic [PW-1:0]   stg_data [STAGES+1];

  assign stg_valid[0] = accept;
  assign stg_data[0]  = {last_d, err_d, y_d};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    hdub_core_logic_pipe_stage #(.W(PW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .in_valid  (stg_valid[i]),
      .in_data   (stg_data[i]),
      .out_valid (stg_valid[i+1]),
      .out_data  (stg_data[i+1])
    );
  end

  assign out_valid                 = stg_valid[STAGES];
  assign {out_last, out_err, out_y} = stg_data[STAGES];

endmodule
